// File: rtl/cfg_writer_pkg.sv
// rtl/cfg_writer_pkg.sv - shared types and constants for the configuration frame writer
package cfg_writer_pkg;

   typedef enum logic [2:0] {
      HUNT,
      ADDR,
      DATA,
      STROBE,
      GAP
   } state_t;

   localparam logic [7:0]  END_ADDR          = 8'hFF;
   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

   function automatic int frame_bytes(input int frame_bits);
      return frame_bits / 8;
   endfunction

endpackage

// File: rtl/frame_sync_detect.sv
// rtl/frame_sync_detect.sv - sliding 32-bit byte window that flags the session sync word
module frame_sync_detect
   import cfg_writer_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       clear,
   input  logic [7:0] byte_in,
   input  logic       byte_en,
   output logic       match
);

   logic [31:0] window;
   logic [31:0] updated;

   // Match looks at the window including the byte being accepted this cycle.
   assign updated = (window << 8) | {24'd0, byte_in};
   assign match   = byte_en && (updated == SYNC_WORD);

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         window <= '0;
      end else if (byte_en) begin
         window <= updated;
      end
   end

endmodule

// File: rtl/config_frame_writer.sv
// rtl/config_frame_writer.sv - sync-hunting configuration frame writer driving latch D/E lines
module config_frame_writer
   import cfg_writer_pkg::*;
#(
   parameter int          FRAME_BITS    = 32,
   parameter int          NUM_COLUMNS   = 16,
   parameter int          STROBE_CYCLES = 2,
   parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [FRAME_BITS-1:0]  frame_data,
   output logic [NUM_COLUMNS-1:0] frame_strobe,
   output logic                   active,
   output logic                   done,
   output logic                   err_addr
);

   localparam int                     BYTES      = frame_bytes(FRAME_BITS);
   localparam logic [NUM_COLUMNS-1:0] STROBE_ONE = NUM_COLUMNS'(1);

   state_t                  state;
   state_t                  state_d;
   logic                    accept;
   logic                    sync_match;
   logic                    sync_clear;
   logic                    last_byte;
   logic                    strobe_last;
   logic                    discard;
   logic [7:0]              column;
   logic [15:0]             byte_cnt;
   logic [15:0]             strobe_cnt;
   logic [FRAME_BITS-1:0]   shift_reg;
   logic [FRAME_BITS-1:0]   assembled;

   assign s_ready     = (state == HUNT) || (state == ADDR) || (state == DATA);
   assign accept      = s_valid && s_ready;
   assign last_byte   = (byte_cnt == 16'(BYTES - 1));
   assign strobe_last = (strobe_cnt == 16'(STROBE_CYCLES - 1));
   assign assembled   = (shift_reg << 8) | FRAME_BITS'(s_data);

   frame_sync_detect #(
      .SYNC_WORD(SYNC_WORD)
   ) u_sync (
      .CLK    (CLK),
      .RST    (RST),
      .clear  (sync_clear),
      .byte_in(s_data),
      .byte_en(accept && (state == HUNT)),
      .match  (sync_match)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= HUNT;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d    = state;
      sync_clear = 1'b0;
      case (state)
         HUNT: begin
            if (sync_match) state_d = ADDR;
         end
         ADDR: begin
            if (accept) begin
               if (s_data == END_ADDR) begin
                  state_d    = HUNT;
                  sync_clear = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept && last_byte) state_d = discard ? GAP : STROBE;
         end
         STROBE: begin
            if (strobe_last) state_d = GAP;
         end
         GAP: begin
            state_d = ADDR;
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // frame_data only moves on the last data byte, which is never within a
   // strobe or the gap cycle that follows it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         frame_data   <= '0;
         frame_strobe <= '0;
         active       <= 1'b0;
         done         <= 1'b0;
         err_addr     <= 1'b0;
         discard      <= 1'b0;
         column       <= '0;
         byte_cnt     <= '0;
         strobe_cnt   <= '0;
         shift_reg    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            HUNT: begin
               if (sync_match) active <= 1'b1;
            end
            ADDR: begin
               if (accept) begin
                  byte_cnt <= '0;
                  if (s_data == END_ADDR) begin
                     done   <= 1'b1;
                     active <= 1'b0;
                  end else if ({24'd0, s_data} < 32'(NUM_COLUMNS)) begin
                     column  <= s_data;
                     discard <= 1'b0;
                  end else begin
                     err_addr <= 1'b1;
                     discard  <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  shift_reg <= assembled;
                  byte_cnt  <= byte_cnt + 16'd1;
                  if (last_byte) begin
                     frame_data <= assembled;
                     strobe_cnt <= '0;
                     if (!discard) frame_strobe <= STROBE_ONE << column;
                  end
               end
            end
            STROBE: begin
               strobe_cnt <= strobe_cnt + 16'd1;
               if (strobe_last) frame_strobe <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_frame_writer.sv
// tb/tb_config_frame_writer.sv - randomized self-checking bench for config_frame_writer
module tb_config_frame_writer;

   logic        CLK;
   logic        RST;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] frame_data;
   logic [15:0] frame_strobe;
   logic        active;
   logic        done;
   logic        err_addr;

   int errors = 0;
   int checks = 0;

   logic [7:0]  sent[$];
   logic [47:0] obs_ev[$];
   logic [47:0] exp_ev[$];
   int          done_seen;
   int          viol;
   int          exp_done;
   logic        exp_err;
   logic        exp_active;

   config_frame_writer dut (
      .CLK         (CLK),
      .RST         (RST),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .frame_data  (frame_data),
      .frame_strobe(frame_strobe),
      .active      (active),
      .done        (done),
      .err_addr    (err_addr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Records each strobe pulse as {column, frame_data, width} and counts
   // protocol violations (multi-hot strobe, data moving under/after a strobe).
   initial begin
      logic [15:0] prev_strobe;
      logic [31:0] prev_data;
      logic [47:0] ev;
      logic [7:0]  col;
      prev_strobe = '0;
      prev_data   = '0;
      done_seen   = 0;
      viol        = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (RST !== 1'b0) begin
            prev_strobe = '0;
            prev_data   = frame_data;
         end else begin
            if (done === 1'b1) done_seen++;
            if ($countones(frame_strobe) > 1) viol++;
            if (prev_strobe != 0 && frame_data !== prev_data) viol++;
            if (frame_strobe != 0) begin
               if (prev_strobe == 0) begin
                  col = 8'd0;
                  for (int i = 0; i < 16; i++) if (frame_strobe[i]) col = i[7:0];
                  obs_ev.push_back({col, frame_data, 8'd1});
               end else if (frame_strobe == prev_strobe) begin
                  ev = obs_ev.pop_back();
                  ev[7:0] = ev[7:0] + 8'd1;
                  obs_ev.push_back(ev);
               end else begin
                  viol++;
               end
            end
            prev_strobe = frame_strobe;
            prev_data   = frame_data;
         end
      end
   end

   // Reference: parse the accepted byte stream into sessions and frames.
   task automatic run_model();
      logic [31:0] win;
      logic [7:0]  a;
      logic [31:0] d;
      int          i;
      bit          insess;
      win = 0; i = 0; insess = 0;
      exp_ev.delete(); exp_done = 0; exp_err = 0;
      while (i < sent.size()) begin
         if (!insess) begin
            win = {win[23:0], sent[i]};
            i++;
            if (win == 32'hFAB0_FAB1) insess = 1;
         end else begin
            a = sent[i];
            i++;
            if (a == 8'hFF) begin
               exp_done++; insess = 0; win = 0;
            end else begin
               if (a >= 8'd16) exp_err = 1;
               if (i + 4 > sent.size()) break;
               d = {sent[i], sent[i+1], sent[i+2], sent[i+3]};
               i += 4;
               if (a < 8'd16) exp_ev.push_back({a, d, 8'd2});
            end
         end
      end
      exp_active = insess;
   endtask

   task automatic do_reset();
      RST = 1'b1; s_valid = 1'b0; s_data = 8'h00;
      @(negedge CLK); @(negedge CLK);
      RST = 1'b0;
      sent.delete(); obs_ev.delete(); done_seen = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int n;
      for (int k = 0; k < stall; k++) begin
         s_valid = 1'b0; s_data = 8'($urandom); @(negedge CLK);
      end
      s_valid = 1'b1; s_data = b; n = 0;
      while (s_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL send_timeout byte=%h s_ready=%b required=1", b, s_ready);
      end else begin
         sent.push_back(b);
      end
      @(negedge CLK);
      s_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] q[$], input int max_stall);
      foreach (q[i]) send_byte(q[i], $urandom_range(0, max_stall));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1; s_valid = 1'b0; s_data = 8'h00;
      @(negedge CLK); @(negedge CLK);
      checks++; if (frame_strobe !== 16'h0) begin errors++; $display("FAIL reset_strobe got=%h want=0", frame_strobe); end
      checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", frame_data); end
      checks++; if ({active, done, err_addr} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {active, done, err_addr}); end
      RST = 1'b0;
      @(negedge CLK);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", s_ready); end
      sent.delete(); obs_ev.delete(); done_seen = 0;
   endtask

   task automatic test_basic();
      do_reset();
      send_seq('{8'hFA, 8'hB0, 8'hFA, 8'hB1}, 0);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active got=%b want=1", active); end
      send_seq('{8'h03, 8'hDE, 8'hAD, 8'hBE}, 0);
      checks++; if (frame_data !== 32'h0) begin errors++; $display("FAIL basic_data_held got=%h want=0", frame_data); end
      send_byte(8'hEF, 0);
      checks++; if (frame_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got=%h want=deadbeef", frame_data); end
      checks++; if ({frame_strobe, s_ready} !== {16'h0008, 1'b0}) begin errors++; $display("FAIL basic_strobe1 got=%h/%b want=0008/0", frame_strobe, s_ready); end
      @(negedge CLK);
      checks++; if ({frame_strobe, s_ready} !== {16'h0008, 1'b0}) begin errors++; $display("FAIL basic_strobe2 got=%h/%b want=0008/0", frame_strobe, s_ready); end
      @(negedge CLK);
      checks++; if ({frame_strobe, s_ready} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL basic_gap got=%h/%b want=0000/0", frame_strobe, s_ready); end
      @(negedge CLK);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b want=1", s_ready); end
      checks++; if (obs_ev.size() != 1 || obs_ev[0] !== {8'd3, 32'hDEADBEEF, 8'd2}) begin errors++; $display("FAIL basic_events n=%0d first=%h want=1 x 03deadbeef02", obs_ev.size(), obs_ev.size() ? obs_ev[0] : 48'h0); end
   endtask

   task automatic test_sync_hunt();
      do_reset();
      send_seq('{8'h00, 8'hFA, 8'hB0, 8'hFA, 8'hFA, 8'hB0, 8'hFA}, 0);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL hunt_early_active got=%b want=0", active); end
      send_seq('{8'hB1, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
      idle(6);
      run_model();
      checks++; if (obs_ev.size() != exp_ev.size()) begin errors++; $display("FAIL hunt_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
      else foreach (exp_ev[i]) begin
         checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL hunt_event%0d got=%h want=%h", i, obs_ev[i], exp_ev[i]); end
      end
   endtask

   task automatic test_bad_addr();
      do_reset();
      send_seq('{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
      idle(4);
      checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL bad_err got=%b want=1", err_addr); end
      checks++; if (obs_ev.size() != 0) begin errors++; $display("FAIL bad_no_strobe got=%0d want=0", obs_ev.size()); end
      send_seq('{8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1);
      idle(6);
      run_model();
      checks++; if (err_addr !== exp_err) begin errors++; $display("FAIL bad_err_sticky got=%b want=%b", err_addr, exp_err); end
      checks++; if (obs_ev.size() != exp_ev.size()) begin errors++; $display("FAIL bad_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
      else foreach (exp_ev[i]) begin
         checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL bad_event%0d got=%h want=%h", i, obs_ev[i], exp_ev[i]); end
      end
   endtask

   task automatic test_end_stall();
      do_reset();
      send_seq('{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h02}, 0);
      send_byte(8'h5A, 3); send_byte(8'hC3, 3); send_byte(8'h0F, 3); send_byte(8'h96, 3);
      idle(4);
      send_seq('{8'hFF, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 0);
      idle(6);
      run_model();
      checks++; if (obs_ev.size() != exp_ev.size()) begin errors++; $display("FAIL end_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
      else foreach (exp_ev[i]) begin
         checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL end_event%0d got=%h want=%h", i, obs_ev[i], exp_ev[i]); end
      end
      checks++; if (done_seen != exp_done) begin errors++; $display("FAIL end_done got=%0d want=%0d", done_seen, exp_done); end
      checks++; if (active !== exp_active) begin errors++; $display("FAIL end_active got=%b want=%b", active, exp_active); end
   endtask

   task automatic test_reset_mid_strobe();
      do_reset();
      send_seq('{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
      checks++; if (frame_strobe !== 16'h0020) begin errors++; $display("FAIL mid_strobe_on got=%h want=0020", frame_strobe); end
      RST = 1'b1;
      @(negedge CLK);
      checks++; if ({frame_strobe, frame_data, active} !== 49'h0) begin errors++; $display("FAIL mid_reset got=%h/%h/%b want=0/0/0", frame_strobe, frame_data, active); end
      RST = 1'b0;
      sent.delete(); obs_ev.delete(); done_seen = 0;
      send_seq('{8'h05, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
      idle(4);
      checks++; if (obs_ev.size() != 0) begin errors++; $display("FAIL mid_nosync_strobe got=%0d want=0", obs_ev.size()); end
      send_seq('{8'hFA, 8'hB0, 8'hFA, 8'hB1, 8'h07, 8'h99, 8'h88, 8'h77, 8'h66}, 0);
      idle(6);
      run_model();
      checks++; if (obs_ev.size() != exp_ev.size()) begin errors++; $display("FAIL mid_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
      else foreach (exp_ev[i]) begin
         checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL mid_event%0d got=%h want=%h", i, obs_ev[i], exp_ev[i]); end
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      for (int it = 0; it < 6; it++) begin
         do_reset();
         q.delete();
         for (int j = 0; j < $urandom_range(0, 6); j++) q.push_back(8'($urandom));
         for (int s = 0; s < 2; s++) begin
            q.push_back(8'hFA); q.push_back(8'hB0); q.push_back(8'hFA); q.push_back(8'hB1);
            for (int f = 0; f < $urandom_range(1, 4); f++) begin
               q.push_back(8'($urandom_range(0, 19)));
               for (int b = 0; b < 4; b++) q.push_back(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
               q.push_back(8'hFF);
               for (int j = 0; j < $urandom_range(0, 3); j++) q.push_back(8'($urandom));
            end
         end
         send_seq(q, 2);
         idle(8);
         run_model();
         checks++; if (obs_ev.size() != exp_ev.size()) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", it, obs_ev.size(), exp_ev.size()); end
         else foreach (exp_ev[i]) begin
            checks++; if (obs_ev[i] !== exp_ev[i]) begin errors++; $display("FAIL rand%0d_event%0d got=%h want=%h", it, i, obs_ev[i], exp_ev[i]); end
         end
         checks++; if (err_addr !== exp_err) begin errors++; $display("FAIL rand%0d_err got=%b want=%b", it, err_addr, exp_err); end
         checks++; if (done_seen != exp_done) begin errors++; $display("FAIL rand%0d_done got=%0d want=%0d", it, done_seen, exp_done); end
         checks++; if (active !== exp_active) begin errors++; $display("FAIL rand%0d_active got=%b want=%b", it, active, exp_active); end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL strobe_invariants got=%0d violations want=0", viol); end
   endtask

   initial begin
      RST = 1'b1; s_valid = 1'b0; s_data = 8'h00;
      @(negedge CLK);
      test_reset();
      test_basic();
      test_sync_hunt();
      test_bad_addr();
      test_end_stall();
      test_reset_mid_strobe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
